// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// serial_sub_ctrl
// ----------------------------------------------------------------------------
// Bit-serial unsigned subtractor (diff = a - b mod 2^WIDTH) with a small
// IDLE / RUN / DONE controller. One operand bit is processed per clock,
// LSB first. Two half-subtract stages and a borrow flip-flop form the
// datapath.
//
// Parameters
//   WIDTH   operand / result width in bits (2..32)
//
// Ports
//   clk     clock, all state updates on the rising edge
//   rst_n   asynchronous active-low reset
//   start   request a subtraction (accepted in IDLE or DONE)
//   a, b    minuend / subtrahend, captured when start is accepted
//   busy    high while the serial computation is running
//   done    one-cycle pulse while the result is fresh
//   diff    registered result, held until the next completion
//   borrow  registered final borrow (1 when a < b unsigned)
//   zero    registered diff == 0 flag (only with SERIAL_SUB_ZERO_FLAG_EN)
//
// Build option
//   `define SERIAL_SUB_ZERO_FLAG_EN  adds the zero output and its register.
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // ------------------------------------------------------------------
    // Serial datapath: two half-subtract stages feeding the borrow flop.
    // ------------------------------------------------------------------
    logic a_bit, b_bit;
    logic hs1_diff, hs1_borrow;
    logic bit_diff, hs2_borrow;
    logic br_nxt;
    logic last_bit;
    logic accept;

    assign a_bit      = a_q[cnt_q];
    assign b_bit      = b_q[cnt_q];
    assign hs1_diff   = a_bit ^ b_bit;
    assign hs1_borrow = ~a_bit & b_bit;
    assign bit_diff   = hs1_diff ^ br_q;
    assign hs2_borrow = ~hs1_diff & br_q;
    assign br_nxt     = hs1_borrow | hs2_borrow;

    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    // New operands are taken from IDLE, or straight out of DONE so that
    // back-to-back operations need no idle cycle. RUN ignores start.
    assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from state, so busy and done are exclusive)
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        d_sh_d   = d_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        if (accept) begin
            a_d    = a;
            b_d    = b;
            br_d   = 1'b0;
            cnt_d  = '0;
            d_sh_d = '0;
        end else if (state_q == S_RUN) begin
            d_sh_d[cnt_q] = bit_diff;
            br_d          = br_nxt;
            if (last_bit) begin
                // Publish the completed word on the edge that enters DONE;
                // the counter parks at WIDTH-1 instead of wrapping.
                diff_d   = d_sh_d;
                borrow_d = br_nxt;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                zero_d   = (d_sh_d == '0);
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_sh_q   <= d_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule
